scoreboard_warp: RTL
====================

Name: scoreboard_warp

Overview:
Per-warp scoreboard that answers the instruction buffer's issue-time queries. It tracks in-flight instructions of one warp in 4 entries, reports RAW, WAW and memory-order hazards, and allocates the entry ID on each granted issue. Entries are released by register writeback from the WB stage and by replay-completion notices from the instruction buffer. It sits beside IBuffer_warp, one instance per warp, between the IU grant and the OC/WB stages.

Parameters:
NUM_ENTRIES, 4, number of entries; fixed at 4 because the ScbID width is 2 bits.
REG_ID_W, 5, register ID width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
Src1_IB_Scb  in  5  source-1 register of the instruction at the buffer head
Src2_IB_Scb  in  5  source-2 register
Dst_IB_Scb  in  5  destination register
Src1_Valid_IB_Scb  in  1  Src1 is used
Src2_Valid_IB_Scb  in  1  Src2 is used
Dst_Valid_IB_Scb  in  1  instruction writes Dst
RP_Grt_IB_Scb  in  1  head instruction issued; allocate an entry
Replayable_IB_Scb  in  1  head instruction is LW/SW
Replay_Complete_IB_Scb  in  1  replay of a memory instruction finished
Replay_Complete_ScbID_IB_Scb  in  2  entry that finished replay
Replay_Complete_SW_LWbar_IB_Scb  in  1  1 = SW, 0 = LW
Clear_Valid_WB_Scb  in  1  register writeback done
Clear_ScbID_WB_Scb  in  2  entry being written back
Full_Scb_IB  out  1  all entries busy
Empty_Scb_IB  out  1  no entry busy
Dependent_Scb_IB  out  1  head instruction has a hazard
ScbID_Scb_IB  out  2  entry allocated on RP_Grt

Behaviour:
- Per-entry state: Valid, Dst[4:0], PendWB (waiting for writeback), Incomplete (waiting for replay completion).
- Reset (async, rst=1): all state bits cleared. Outputs: Full=0, Empty=1, Dependent=0, ScbID=0.
- Free vector = ~Valid, taken from registered state.
- ScbID_Scb_IB is combinational: the lowest-index free entry. When Full=1 it is 0.
- Full = &Valid. Empty = ~|Valid. Both come from registered state.
- Allocate on RP_Grt with Full=0. At the next edge, entry[ScbID] is written:
  - Valid=1
  - Dst=Dst_IB_Scb
  - PendWB=Dst_Valid_IB_Scb
  - Incomplete=Replayable_IB_Scb
- If neither PendWB nor Incomplete would be set (e.g. a branch), the entry is not allocated. ScbID is still driven.
- RP_Grt while Full=1 is a protocol violation: ignored, no state change.
- Writeback clear (Clear_Valid_WB_Scb): PendWB[Clear_ScbID] <= 0.
- Replay completion (Replay_Complete_IB_Scb):
  - SW_LWbar=1: Incomplete <= 0 and PendWB <= 0.
  - SW_LWbar=0: Incomplete <= 0 only; the LW still waits for its writeback.
- Release: an entry's Valid <= 0 at the same edge its last outstanding bit (PendWB or Incomplete) clears. Writeback and replay clears to the same entry in one cycle both apply.
- A clear aimed at an entry with Valid=0 is ignored.
- Simultaneous allocate and release: allocation uses the pre-edge free vector. A slot freed this cycle is not reused until the next cycle. Releasing one slot and allocating another in the same cycle is legal.
- Dependent_Scb_IB is combinational from registered state only. It is 1 if any of the following holds:
  - RAW: Src1_Valid & Src1!=0 & Src1 matches a Valid&PendWB entry's Dst; same test for Src2.
  - WAW: Dst_Valid & Dst!=0 & Dst matches a Valid&PendWB entry's Dst.
  - Memory order: Replayable_IB_Scb & any Valid&Incomplete entry.
- R0 never creates a dependency.
- An entry whose clear arrives this cycle still counts as a hazard this cycle. There is no same-cycle bypass.
- Latency: allocation and clears become visible in Full, Empty and Dependent one cycle after the edge.
- Reset asserted mid-operation: all entries are dropped immediately; pending clears afterwards are ignored as clears to invalid entries.

Test Plan:
- Reset -> Empty=1, Full=0, ScbID=0, Dependent=0. Four grants with Dst=R1..R4 and Dst_Valid=1 -> ScbID 0,1,2,3 on successive grants; Full=1 after the 4th edge, Empty=0.
- RAW: entry0 holds Dst=R5 PendWB. Present Src1=R5 Src1_Valid=1 -> Dependent=1. Clear_Valid with ID 0 -> Dependent=0 on the next cycle and entry0 freed.
- R0 exclusion: entry holds Dst=R0 pending; present Src1=R0 -> Dependent=0. WAW: entry holds Dst=R7; present Dst=R7 Dst_Valid=1 -> Dependent=1.
- LW lifecycle: grant Replayable=1, Dst=R3 -> ID 0. Replay_Complete ID 0 SW_LWbar=0 -> entry stays Valid, Empty=0. Clear_Valid ID 0 -> Empty=1. SW: grant Replayable=1 Dst_Valid=0; Replay_Complete SW_LWbar=1 -> Empty=1 next cycle.
- Memory order: one Incomplete entry exists; present Replayable=1 with no register overlap -> Dependent=1. Present Replayable=0 -> Dependent=0.
- Full, then in the same cycle RP_Grt plus Clear_Valid on ID 2 -> grant ignored; entry2 freed. Next cycle ScbID=2, Full=0. Then RP_Grt -> ID 2 allocated, Full=1. Reset mid-flight -> Empty=1 asynchronously.

Source files
------------

// File: rtl/scoreboard_warp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scoreboard_warp_if : issue-query / writeback bundle of scoreboard    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface scoreboard_warp_if #(
  parameter int REG_ID_W = 5,
  parameter int ID_W     = 2
);
  logic [REG_ID_W-1:0] Src1_IB_Scb;
  logic [REG_ID_W-1:0] Src2_IB_Scb;
  logic [REG_ID_W-1:0] Dst_IB_Scb;
  logic                Src1_Valid_IB_Scb;
  logic                Src2_Valid_IB_Scb;
  logic                Dst_Valid_IB_Scb;
  logic                RP_Grt_IB_Scb;
  logic                Replayable_IB_Scb;
  logic                Replay_Complete_IB_Scb;
  logic [ID_W-1:0]     Replay_Complete_ScbID_IB_Scb;
  logic                Replay_Complete_SW_LWbar_IB_Scb;
  logic                Clear_Valid_WB_Scb;
  logic [ID_W-1:0]     Clear_ScbID_WB_Scb;
  logic                Full_Scb_IB;
  logic                Empty_Scb_IB;
  logic                Dependent_Scb_IB;
  logic [ID_W-1:0]     ScbID_Scb_IB;

  modport master (
    output Src1_IB_Scb, Src2_IB_Scb, Dst_IB_Scb,
    output Src1_Valid_IB_Scb, Src2_Valid_IB_Scb, Dst_Valid_IB_Scb,
    output RP_Grt_IB_Scb, Replayable_IB_Scb,
    output Replay_Complete_IB_Scb, Replay_Complete_ScbID_IB_Scb,
    output Replay_Complete_SW_LWbar_IB_Scb,
    output Clear_Valid_WB_Scb, Clear_ScbID_WB_Scb,
    input  Full_Scb_IB, Empty_Scb_IB, Dependent_Scb_IB, ScbID_Scb_IB
  );

  modport slave (
    input  Src1_IB_Scb, Src2_IB_Scb, Dst_IB_Scb,
    input  Src1_Valid_IB_Scb, Src2_Valid_IB_Scb, Dst_Valid_IB_Scb,
    input  RP_Grt_IB_Scb, Replayable_IB_Scb,
    input  Replay_Complete_IB_Scb, Replay_Complete_ScbID_IB_Scb,
    input  Replay_Complete_SW_LWbar_IB_Scb,
    input  Clear_Valid_WB_Scb, Clear_ScbID_WB_Scb,
    output Full_Scb_IB, Empty_Scb_IB, Dependent_Scb_IB, ScbID_Scb_IB
  );
endinterface
`default_nettype wire

// File: rtl/scoreboard_warp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scoreboard_warp : per-warp 4-entry RAW/WAW/memory-order scoreboard   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module scoreboard_warp #(
  parameter int NUM_ENTRIES = 4,
  parameter int REG_ID_W    = 5
) (
  input  wire logic              clk,
  input  wire logic              rst,
  scoreboard_warp_if.slave       scb_io
);
  localparam int ID_W = 2;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] pend_q,  pend_d;
  logic [NUM_ENTRIES-1:0] inc_q,   inc_d;
  logic [REG_ID_W-1:0]    dst_q [NUM_ENTRIES];
  logic [REG_ID_W-1:0]    dst_d [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] free_w;
  logic [ID_W-1:0]        scbid_w;
  logic                   full_w;
  logic                   alloc_w;
  logic                   dep_w;

  assign free_w = ~valid_q;
  assign full_w = &valid_q;

  // Lowest-index free entry; stays 0 when nothing is free.
  always_comb begin
    scbid_w = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_w[i]) scbid_w = ID_W'(i);
    end
  end

  // Instructions with nothing to wait for (e.g. branches) take no entry.
  assign alloc_w = scb_io.RP_Grt_IB_Scb & ~full_w &
                   (scb_io.Dst_Valid_IB_Scb | scb_io.Replayable_IB_Scb);

  always_comb begin
    pend_d  = pend_q;
    inc_d   = inc_q;
    valid_d = valid_q;
    dst_d   = dst_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i]) begin
        if (scb_io.Clear_Valid_WB_Scb && (scb_io.Clear_ScbID_WB_Scb == ID_W'(i)))
          pend_d[i] = 1'b0;
        if (scb_io.Replay_Complete_IB_Scb &&
            (scb_io.Replay_Complete_ScbID_IB_Scb == ID_W'(i))) begin
          inc_d[i] = 1'b0;
          if (scb_io.Replay_Complete_SW_LWbar_IB_Scb) pend_d[i] = 1'b0;
        end
        valid_d[i] = pend_d[i] | inc_d[i];
      end
      // Allocation only targets a pre-edge free slot, so it never collides with clears.
      if (alloc_w && (scbid_w == ID_W'(i))) begin
        valid_d[i] = 1'b1;
        dst_d[i]   = scb_io.Dst_IB_Scb;
        pend_d[i]  = scb_io.Dst_Valid_IB_Scb;
        inc_d[i]   = scb_io.Replayable_IB_Scb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      pend_q  <= '0;
      inc_q   <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) dst_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      inc_q   <= inc_d;
      dst_q   <= dst_d;
    end
  end

  // Hazards look only at registered state: no same-cycle clear bypass.
  always_comb begin
    dep_w = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && pend_q[i]) begin
        if (scb_io.Src1_Valid_IB_Scb && (scb_io.Src1_IB_Scb != '0) &&
            (scb_io.Src1_IB_Scb == dst_q[i])) dep_w = 1'b1;
        if (scb_io.Src2_Valid_IB_Scb && (scb_io.Src2_IB_Scb != '0) &&
            (scb_io.Src2_IB_Scb == dst_q[i])) dep_w = 1'b1;
        if (scb_io.Dst_Valid_IB_Scb && (scb_io.Dst_IB_Scb != '0) &&
            (scb_io.Dst_IB_Scb == dst_q[i])) dep_w = 1'b1;
      end
    end
    if (scb_io.Replayable_IB_Scb && |(valid_q & inc_q)) dep_w = 1'b1;
  end

  assign scb_io.Full_Scb_IB      = full_w;
  assign scb_io.Empty_Scb_IB     = ~|valid_q;
  assign scb_io.Dependent_Scb_IB = dep_w;
  assign scb_io.ScbID_Scb_IB     = scbid_w;

endmodule
`default_nettype wire
